// File: rtl/estado_mascota_pkg.sv
// Shared state codes, level thresholds and need-priority helpers for estado_mascota.
// Priority when several levels are empty: ENFERMO > HAMBRIENTO > CANSADO > TRISTE.
package estado_mascota_pkg;

  typedef enum logic [2:0] {
    FELIZ      = 3'd0,
    NEUTRO     = 3'd1,
    TRISTE     = 3'd2,
    CANSADO    = 3'd3,
    HAMBRIENTO = 3'd4,
    ENFERMO    = 3'd5,
    MUERTO     = 3'd6,
    TEST       = 3'd7
  } estado_t;

  localparam logic [1:0] VACIO = 2'd0;
  localparam logic [1:0] OK    = 2'd2;

  // Lower rank means higher priority; non-need states rank last.
  function automatic logic [1:0] rango(input estado_t s);
    case (s)
      ENFERMO:    rango = 2'd0;
      HAMBRIENTO: rango = 2'd1;
      CANSADO:    rango = 2'd2;
      default:    rango = 2'd3;
    endcase
  endfunction

  // Highest-priority need state among empty levels; FELIZ when none is empty.
  function automatic estado_t mayor_necesidad(input logic [1:0] a, input logic [1:0] e,
                                              input logic [1:0] d, input logic [1:0] m);
    if (m == VACIO)      mayor_necesidad = ENFERMO;
    else if (e == VACIO) mayor_necesidad = HAMBRIENTO;
    else if (d == VACIO) mayor_necesidad = CANSADO;
    else if (a == VACIO) mayor_necesidad = TRISTE;
    else                 mayor_necesidad = FELIZ;
  endfunction

  function automatic estado_t evaluar(input logic [1:0] a, input logic [1:0] e,
                                      input logic [1:0] d, input logic [1:0] m);
    estado_t z;
    z = mayor_necesidad(a, e, d, m);
    if (z != FELIZ)
      evaluar = z;
    else if (a >= OK && e >= OK && d >= OK && m >= OK)
      evaluar = FELIZ;
    else
      evaluar = NEUTRO;
  endfunction

  // {Comida, Medicina, Descanso, Carisia}
  function automatic logic [3:0] activos(input estado_t s);
    case (s)
      FELIZ, NEUTRO: activos = 4'b1111;
      HAMBRIENTO:    activos = 4'b1000;
      ENFERMO:       activos = 4'b0100;
      CANSADO:       activos = 4'b0010;
      TRISTE:        activos = 4'b0001;
      default:       activos = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/estado_mascota_divisor_tick.sv
// divisor_tick: free-running 0..PERIOD-1 counter that pulses tick for one cycle at PERIOD-1.
module divisor_tick #(
  parameter int PERIOD = 2
) (
  input  logic clk,
  input  logic B_reset,
  output logic tick
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!B_reset)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/estado_mascota.sv
// estado_mascota: resolves need levels into the pet state, death timer and test stepping.
// Optional animation frame bit built only with ESTADO_ANIM_EN defined.
module estado_mascota
  import estado_mascota_pkg::*;
#(
  parameter int T_SEG    = 50000000,
  parameter int T_MUERTE = 10,
  parameter int T_ANIM   = 25000000
) (
  input  logic       clk,
  input  logic       B_reset,
  input  logic [1:0] Nivel_Animo,
  input  logic [1:0] Nivel_Energia,
  input  logic [1:0] Nivel_Descanso,
  input  logic [1:0] Nivel_Medicina,
  input  logic       Senal_Test,
  input  logic       Senal_Test_fil,
  output logic [2:0] Estado,
  output logic       Activo_Comida,
  output logic       Activo_Medicina,
  output logic       Activo_Descanso,
  output logic       Activo_Carisia,
  output logic       Muerto,
  output logic       Frame
);

  estado_t    estado_q, estado_d, urgente;
  logic [7:0] cnt_muerte_q, cnt_muerte_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] ceros;
  logic [1:0] propio;
  logic       test_prev_q, subida, bajada, tick_seg;

  divisor_tick #(.PERIOD(T_SEG)) u_seg (
    .clk     (clk),
    .B_reset (B_reset),
    .tick    (tick_seg)
  );

  always_comb begin
    estado_d     = estado_q;
    idx_d        = idx_q;
    cnt_muerte_d = cnt_muerte_q;
    subida       = Senal_Test & ~test_prev_q;
    bajada       = ~Senal_Test & test_prev_q;
    urgente      = mayor_necesidad(Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina);
    ceros        = {2'b00, Nivel_Animo == VACIO} + {2'b00, Nivel_Energia == VACIO} +
                   {2'b00, Nivel_Descanso == VACIO} + {2'b00, Nivel_Medicina == VACIO};
    case (estado_q)
      ENFERMO:    propio = Nivel_Medicina;
      HAMBRIENTO: propio = Nivel_Energia;
      CANSADO:    propio = Nivel_Descanso;
      default:    propio = Nivel_Animo;
    endcase

    if (estado_q == MUERTO) begin
      cnt_muerte_d = 8'd0;
    end else if (estado_q == TEST) begin
      cnt_muerte_d = 8'd0;
      // A simultaneous fall and step pulse: the fall wins.
      if (bajada)
        estado_d = evaluar(Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina);
      else if (Senal_Test_fil)
        idx_d = (idx_q == 3'd6) ? 3'd0 : idx_q + 3'd1;
    end else if (subida) begin
      estado_d     = TEST;
      idx_d        = 3'd0;
      cnt_muerte_d = 8'd0;
    end else begin
      if (ceros < 3'd2)
        cnt_muerte_d = 8'd0;
      else if (tick_seg)
        cnt_muerte_d = cnt_muerte_q + 8'd1;

      if (ceros >= 3'd2 && tick_seg && (cnt_muerte_q + 8'd1) == 8'(T_MUERTE))
        estado_d = MUERTO;
      else if (estado_q == FELIZ || estado_q == NEUTRO)
        estado_d = evaluar(Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina);
      else if (urgente != FELIZ && rango(urgente) < rango(estado_q))
        estado_d = urgente;
      // Hysteresis: a need state is only released once its own level reaches OK.
      else if (propio >= OK)
        estado_d = evaluar(Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina);
    end
  end

  always_ff @(posedge clk) begin
    if (!B_reset) begin
      estado_q        <= FELIZ;
      idx_q           <= 3'd0;
      cnt_muerte_q    <= 8'd0;
      test_prev_q     <= 1'b0;
      Estado          <= 3'd0;
      Activo_Comida   <= 1'b1;
      Activo_Medicina <= 1'b1;
      Activo_Descanso <= 1'b1;
      Activo_Carisia  <= 1'b1;
      Muerto          <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      idx_q        <= idx_d;
      cnt_muerte_q <= cnt_muerte_d;
      test_prev_q  <= Senal_Test;
      Estado       <= (estado_d == TEST) ? idx_d : estado_d;
      {Activo_Comida, Activo_Medicina, Activo_Descanso, Activo_Carisia} <= activos(estado_d);
      Muerto       <= (estado_d == MUERTO);
    end
  end

`ifdef ESTADO_ANIM_EN
  logic tick_anim;

  divisor_tick #(.PERIOD(T_ANIM)) u_anim (
    .clk     (clk),
    .B_reset (B_reset),
    .tick    (tick_anim)
  );

  always_ff @(posedge clk) begin
    if (!B_reset)
      Frame <= 1'b0;
    else if (estado_d == MUERTO)
      Frame <= 1'b0;
    else if (tick_anim)
      Frame <= ~Frame;
  end
`else
  localparam int unused_t_anim = T_ANIM;
  assign Frame = 1'b0;
`endif

endmodule

// File: tb/tb_estado_mascota.sv
// Directed self-checking bench for estado_mascota (T_SEG=10, T_MUERTE=3, T_ANIM=4).
module tb_estado_mascota;
  logic       clk = 1'b0;
  logic       B_reset;
  logic [1:0] Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina;
  logic       Senal_Test, Senal_Test_fil;
  logic [2:0] Estado;
  logic       Activo_Comida, Activo_Medicina, Activo_Descanso, Activo_Carisia;
  logic       Muerto, Frame;
  logic [3:0] act;

  int n_assert = 0;
  int n_fail   = 0;

  estado_mascota #(.T_SEG(10), .T_MUERTE(3), .T_ANIM(4)) dut (
    .clk             (clk),
    .B_reset         (B_reset),
    .Nivel_Animo     (Nivel_Animo),
    .Nivel_Energia   (Nivel_Energia),
    .Nivel_Descanso  (Nivel_Descanso),
    .Nivel_Medicina  (Nivel_Medicina),
    .Senal_Test      (Senal_Test),
    .Senal_Test_fil  (Senal_Test_fil),
    .Estado          (Estado),
    .Activo_Comida   (Activo_Comida),
    .Activo_Medicina (Activo_Medicina),
    .Activo_Descanso (Activo_Descanso),
    .Activo_Carisia  (Activo_Carisia),
    .Muerto          (Muerto),
    .Frame           (Frame)
  );

  always #5 clk = ~clk;

  assign act = {Activo_Comida, Activo_Medicina, Activo_Descanso, Activo_Carisia};

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_lv(input logic [1:0] a, input logic [1:0] e,
                        input logic [1:0] d, input logic [1:0] m);
    Nivel_Animo    = a;
    Nivel_Energia  = e;
    Nivel_Descanso = d;
    Nivel_Medicina = m;
  endtask

  initial begin
    B_reset = 1'b0;
    Senal_Test = 1'b0;
    Senal_Test_fil = 1'b0;
    set_lv(2'd3, 2'd3, 2'd3, 2'd3);
    step(3);
    chk("rst_estado", {5'd0, Estado}, 8'd0);
    chk("rst_activo", {4'd0, act}, 8'hF);
    chk("rst_muerto", {7'd0, Muerto}, 8'd0);
    chk("rst_frame", {7'd0, Frame}, 8'd0);
    B_reset = 1'b1;
    step(1);
    chk("feliz_estado", {5'd0, Estado}, 8'd0);
    chk("feliz_activo", {4'd0, act}, 8'hF);

    // Hunger with hysteresis
    Nivel_Energia = 2'd0; step(1);
    chk("hambre_estado", {5'd0, Estado}, 8'd4);
    chk("hambre_activo", {4'd0, act}, 8'h8);
    Nivel_Energia = 2'd1; step(3);
    chk("hambre_hold", {5'd0, Estado}, 8'd4);
    Nivel_Energia = 2'd2; step(1);
    chk("hambre_salida", {5'd0, Estado}, 8'd0);
    chk("hambre_salida_act", {4'd0, act}, 8'hF);

    // Preemption by medicina
    Nivel_Energia = 2'd0; step(1);
    chk("pre_hambre", {5'd0, Estado}, 8'd4);
    Nivel_Medicina = 2'd0; step(1);
    chk("preempt_enfermo", {5'd0, Estado}, 8'd5);
    chk("preempt_activo", {4'd0, act}, 8'h4);
    set_lv(2'd3, 2'd3, 2'd3, 2'd3); step(1);
    chk("enfermo_salida", {5'd0, Estado}, 8'd0);

    // Neutro, triste, cansado
    Nivel_Descanso = 2'd1; step(1);
    chk("neutro", {5'd0, Estado}, 8'd1);
    Nivel_Animo = 2'd0; step(1);
    chk("triste", {5'd0, Estado}, 8'd2);
    chk("triste_activo", {4'd0, act}, 8'h1);
    Nivel_Animo = 2'd1; step(2);
    chk("triste_hold", {5'd0, Estado}, 8'd2);
    Nivel_Animo = 2'd3; step(1);
    chk("triste_a_neutro", {5'd0, Estado}, 8'd1);
    Nivel_Descanso = 2'd0; step(1);
    chk("cansado", {5'd0, Estado}, 8'd3);
    chk("cansado_activo", {4'd0, act}, 8'h2);
    Nivel_Descanso = 2'd3; step(1);
    chk("cansado_salida", {5'd0, Estado}, 8'd0);

    // Death counter: two ticks, clear, two ticks, then a third fresh tick
    set_lv(2'd0, 2'd3, 2'd0, 2'd3); step(20);
    chk("vivo_2ticks", {7'd0, Muerto}, 8'd0);
    chk("cansado_2ceros", {5'd0, Estado}, 8'd3);
    Nivel_Animo = 2'd3; step(1);
    Nivel_Animo = 2'd0; step(20);
    chk("vivo_tras_clear", {7'd0, Muerto}, 8'd0);
    step(10);
    chk("muerto", {7'd0, Muerto}, 8'd1);
    chk("muerto_estado", {5'd0, Estado}, 8'd6);
    chk("muerto_activo", {4'd0, act}, 8'h0);
    set_lv(2'd3, 2'd3, 2'd3, 2'd3); step(5);
    chk("muerto_terminal", {5'd0, Estado}, 8'd6);
    Senal_Test = 1'b1; step(2);
    chk("muerto_ignora_test", {5'd0, Estado}, 8'd6);
    Senal_Test = 1'b0;
    B_reset = 1'b0; step(2);
    chk("reset_muerto_estado", {5'd0, Estado}, 8'd0);
    chk("reset_muerto_flag", {7'd0, Muerto}, 8'd0);
    B_reset = 1'b1; step(1);
    chk("post_reset_activo", {4'd0, act}, 8'hF);

    // Test mode stepping with wrap
    Senal_Test = 1'b1; step(1);
    chk("test_entrada", {5'd0, Estado}, 8'd0);
    chk("test_activo", {4'd0, act}, 8'h0);
    for (int i = 0; i < 7; i++) begin
      Senal_Test_fil = 1'b1; step(1);
      Senal_Test_fil = 1'b0;
      chk($sformatf("test_idx%0d", i), {5'd0, Estado}, 8'((i + 1) % 7));
    end
    step(2);
    chk("test_idx_hold", {5'd0, Estado}, 8'd0);
    Senal_Test_fil = 1'b1; step(1);
    Senal_Test_fil = 1'b0;
    chk("test_idx_1", {5'd0, Estado}, 8'd1);
    // Fall and step together: the fall wins
    set_lv(2'd1, 2'd3, 2'd3, 2'd3);
    Senal_Test = 1'b0; Senal_Test_fil = 1'b1; step(1);
    Senal_Test_fil = 1'b0;
    chk("test_salida_neutro", {5'd0, Estado}, 8'd1);
    chk("test_salida_activo", {4'd0, act}, 8'hF);

    // Rise with a simultaneous step pulse: index stays 0
    Senal_Test = 1'b1; Senal_Test_fil = 1'b1; step(1);
    Senal_Test_fil = 1'b0;
    chk("test_subida_fil", {5'd0, Estado}, 8'd0);
    set_lv(2'd3, 2'd0, 2'd3, 2'd0); step(40);
    chk("test_sin_muerte", {7'd0, Muerto}, 8'd0);
    chk("test_estado_fijo", {5'd0, Estado}, 8'd0);
    Senal_Test = 1'b0; step(1);
    chk("test_salida_enfermo", {5'd0, Estado}, 8'd5);
    chk("frame_cero", {7'd0, Frame}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
